// File: rtl/tie_level_monitor_if.sv
// rtl/tie_level_monitor_if.sv - control/status bundle between housekeeping and the tie-level monitor

interface tie_level_monitor_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             one_i;
    logic             zero_i;
    logic             fault_clr;
    logic             const_ok;
    logic             fault;
    logic [CNT_W-1:0] fault_count;
    logic             irq;

    modport master (
        output enable, one_i, zero_i, fault_clr,
        input  const_ok, fault, fault_count, irq
    );

    modport slave (
        input  enable, one_i, zero_i, fault_clr,
        output const_ok, fault, fault_count, irq
    );
endinterface

// File: rtl/tie_level_monitor.sv
// rtl/tie_level_monitor.sv - debounced checker for the 1.8V one/zero tie nets; irq built only with TIE_MON_IRQ_EN

module tie_level_monitor #(
    parameter int SETTLE_CYCLES = 64,
    parameter int DEBOUNCE      = 4,
    parameter int CNT_W         = 8
) (
    input logic               clk,
    input logic               resetn,
    tie_level_monitor_if.slave bus
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_OK     = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;

    logic             one_m, zero_m, one_s, zero_s;
    logic             bad;
    logic [2:0]       state, state_nx;
    logic [SW-1:0]    settle_cnt, settle_nx;
    logic [DW-1:0]    deb_cnt, deb_nx, deb_inc;
    logic             new_fault;
    logic             fault_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            one_m  <= 1'b0;
            zero_m <= 1'b0;
            one_s  <= 1'b0;
            zero_s <= 1'b0;
        end else begin
            one_m  <= bus.one_i;
            zero_m <= bus.zero_i;
            one_s  <= one_m;
            zero_s <= zero_m;
        end
    end

    assign bad     = ~one_s | zero_s;
    assign deb_inc = deb_cnt + 1'b1;

    // deb_cnt counts bad samples in CHECK/OK and good samples in FAULT
    always_comb begin
        state_nx  = state;
        settle_nx = settle_cnt;
        deb_nx    = deb_cnt;
        new_fault = 1'b0;
        if (!bus.enable) begin
            state_nx  = S_IDLE;
            settle_nx = '0;
            deb_nx    = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nx  = S_SETTLE;
                    settle_nx = '0;
                    deb_nx    = '0;
                end
                S_SETTLE: begin
                    if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                        state_nx  = S_CHECK;
                        settle_nx = '0;
                    end else begin
                        settle_nx = settle_cnt + 1'b1;
                    end
                end
                S_CHECK, S_OK: begin
                    if (bad) begin
                        if (deb_inc == DW'(DEBOUNCE)) begin
                            state_nx  = S_FAULT;
                            deb_nx    = '0;
                            new_fault = 1'b1;
                        end else begin
                            state_nx = S_CHECK;
                            deb_nx   = deb_inc;
                        end
                    end else begin
                        state_nx = S_OK;
                        deb_nx   = '0;
                    end
                end
                S_FAULT: begin
                    if (bad) begin
                        deb_nx = '0;
                    end else if (deb_inc == DW'(DEBOUNCE)) begin
                        state_nx = S_CHECK;
                        deb_nx   = '0;
                    end else begin
                        deb_nx = deb_inc;
                    end
                end
                default: begin
                    state_nx  = S_IDLE;
                    settle_nx = '0;
                    deb_nx    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            deb_cnt    <= '0;
        end else begin
            state      <= state_nx;
            settle_cnt <= settle_nx;
            deb_cnt    <= deb_nx;
        end
    end

    // A clear coinciding with a new fault still records that fault
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fault_q <= 1'b0;
            count_q <= '0;
        end else if (new_fault) begin
            fault_q <= 1'b1;
            if (bus.fault_clr)
                count_q <= CNT_W'(1);
            else if (count_q != {CNT_W{1'b1}})
                count_q <= count_q + 1'b1;
        end else if (bus.fault_clr) begin
            fault_q <= 1'b0;
            count_q <= '0;
        end
    end

    assign bus.const_ok    = (state == S_OK);
    assign bus.fault       = fault_q;
    assign bus.fault_count = count_q;

`ifdef TIE_MON_IRQ_EN
    logic irq_evt, irq_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            irq_evt <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            irq_evt <= new_fault;
            irq_q   <= irq_evt;
        end
    end

    assign bus.irq = irq_q;
`else
    assign bus.irq = 1'b0;
`endif

endmodule

// File: tb/tb_tie_level_monitor.sv
// tb/tb_tie_level_monitor.sv - scoreboard bench for tie_level_monitor with a behavioural reference model

module tb_tie_level_monitor;
    localparam int SETTLE = 64;
    localparam int DEB    = 4;
    localparam int CW     = 2;
    localparam int CMAX   = (1 << CW) - 1;

    typedef struct {
        bit ok;
        bit fault;
        int count;
        bit irq;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    tie_level_monitor_if #(.CNT_W(CW)) bus ();

    tie_level_monitor #(
        .SETTLE_CYCLES(SETTLE),
        .DEBOUNCE     (DEB),
        .CNT_W        (CW)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endfunction

    // Reference: time since enable, run lengths of bad/good samples, fault episode flag
    int m_en = -1;
    bit m_ok, m_in_fault, m_fault, m_evt, m_irq, m_bad, m_new;
    int m_bad_run, m_good_run, m_count;
    bit p1o, p1z, p2o, p2z;

    always @(posedge clk) begin
        m_bad = !p2o || p2z;
        m_new = 1'b0;
        if (!resetn) begin
            m_en = -1; m_ok = 0; m_in_fault = 0; m_bad_run = 0; m_good_run = 0;
            m_fault = 0; m_count = 0; m_evt = 0; m_irq = 0;
            p1o = 0; p1z = 0; p2o = 0; p2z = 0;
        end else begin
            if (!bus.enable) begin
                m_en = -1; m_ok = 0; m_in_fault = 0; m_bad_run = 0; m_good_run = 0;
            end else if (m_en < SETTLE) begin
                m_en++;
            end else if (m_in_fault) begin
                m_good_run = m_bad ? 0 : m_good_run + 1;
                if (m_good_run == DEB) begin
                    m_in_fault = 0;
                    m_good_run = 0;
                end
            end else if (m_bad) begin
                m_ok = 0;
                m_bad_run++;
                if (m_bad_run == DEB) begin
                    m_new = 1; m_in_fault = 1; m_bad_run = 0;
                end
            end else begin
                m_ok = 1;
                m_bad_run = 0;
            end
            if (m_new) begin
                m_fault = 1;
                m_count = bus.fault_clr ? 1 : ((m_count < CMAX) ? m_count + 1 : CMAX);
            end else if (bus.fault_clr) begin
                m_fault = 0;
                m_count = 0;
            end
`ifdef TIE_MON_IRQ_EN
            m_irq = m_evt;
            m_evt = m_new;
`endif
            p2o = p1o; p2z = p1z;
            p1o = bus.one_i; p1z = bus.zero_i;
        end
        sb.push_back('{m_ok, m_fault, m_count, m_irq});
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_const_ok",    32'(bus.const_ok),    32'(e.ok));
            chk("sb_fault",       32'(bus.fault),       32'(e.fault));
            chk("sb_fault_count", 32'(bus.fault_count), 32'(e.count));
            chk("sb_irq",         32'(bus.irq),         32'(e.irq));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int run_left;
        bus.enable = 0; bus.one_i = 1; bus.zero_i = 0; bus.fault_clr = 0;
        resetn = 0;
        step(3);
        chk("reset_const_ok", 32'(bus.const_ok), 0);
        chk("reset_fault",    32'(bus.fault), 0);
        chk("reset_count",    32'(bus.fault_count), 0);
        chk("reset_irq",      32'(bus.irq), 0);
        resetn = 1;

        bus.enable = 1;
        step(67);
        chk("settle_ok",    32'(bus.const_ok), 1);
        chk("settle_fault", 32'(bus.fault), 0);

        bus.zero_i = 1; step(3); bus.zero_i = 0; step(8);
        chk("glitch_ok",    32'(bus.const_ok), 1);
        chk("glitch_fault", 32'(bus.fault), 0);

        bus.one_i = 0; step(5);
        chk("fault_not_yet", 32'(bus.fault), 0);
        step(1);
        chk("fault_set",   32'(bus.fault), 1);
        chk("fault_count1", 32'(bus.fault_count), 1);
        step(4); bus.one_i = 1; step(12);
        chk("recover_ok", 32'(bus.const_ok), 1);

        bus.one_i = 0; step(5);
        bus.fault_clr = 1; step(1); bus.fault_clr = 0;
        chk("clr_coincide_fault", 32'(bus.fault), 1);
        chk("clr_coincide_count", 32'(bus.fault_count), 1);
        step(4); bus.one_i = 1; step(12);
        bus.fault_clr = 1; step(1); bus.fault_clr = 0;
        chk("clr_fault", 32'(bus.fault), 0);
        chk("clr_count", 32'(bus.fault_count), 0);
        chk("clr_keeps_ok", 32'(bus.const_ok), 1);

        repeat (5) begin
            bus.one_i = 0; step(10);
            bus.one_i = 1; step(12);
        end
        chk("sat_count", 32'(bus.fault_count), CMAX);
        chk("sat_fault", 32'(bus.fault), 1);

        bus.enable = 0; step(2);
        bus.enable = 1; step(30);
        bus.enable = 0; step(3);
        bus.enable = 1; step(60);
        chk("resettle_early", 32'(bus.const_ok), 0);
        step(7);
        chk("resettle_ok", 32'(bus.const_ok), 1);

        resetn = 0; step(1);
        chk("midreset_ok",    32'(bus.const_ok), 0);
        chk("midreset_fault", 32'(bus.fault), 0);
        chk("midreset_count", 32'(bus.fault_count), 0);
        resetn = 1;

        run_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (run_left == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    run_left = $urandom_range(1, 8);
                    case ($urandom_range(0, 2))
                        0: begin bus.one_i = 0; bus.zero_i = 0; end
                        1: begin bus.one_i = 1; bus.zero_i = 1; end
                        default: begin bus.one_i = 0; bus.zero_i = 1; end
                    endcase
                end else begin
                    run_left = $urandom_range(1, 20);
                    bus.one_i = 1; bus.zero_i = 0;
                end
            end
            run_left--;
            bus.fault_clr = ($urandom_range(0, 39) == 0);
            bus.enable    = ($urandom_range(0, 799) != 0);
            resetn        = ($urandom_range(0, 1999) != 0);
            step(1);
        end

        resetn = 1; bus.fault_clr = 0;
        step(2);
        @(negedge clk); #1;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
